pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 138 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage: decouples upstream ready from downstream ready.
// Latency: 1 cycle from push to valid_o when empty; full throughput with ready_i held high.
// Backpressure: ready_o is registered, drops only when both MAIN and SKID are occupied.
//
// Ports:
//   clk_i, rst_i (async, active-low), flush_i (sync, empties the stage)
//   valid_i/ready_o/data_i   : upstream handshake and payload
//   valid_o/ready_i/data_o   : downstream handshake and payload (data_o driven by MAIN)
//   count_o                  : occupancy 0..2
//   stall_cnt_o              : saturating count of cycles with valid_o=1 and ready_i=0
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic [1:0]        count_q, count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic push;
  logic pop;

  // Handshakes use the registered outputs only, so ready_o never sees ready_i.
  assign push = valid_i & ready_q;
  assign pop  = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_d  = data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = data_i;
        end else if (push) begin
          skid_d  = data_i;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // ready_o is low here, so no push can coincide with this state.
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush wins over any handshake in the same cycle; the pushed word is lost.
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  // Outputs are registered copies derived from the next state.
  always_comb begin
    ready_d = (state_d != ST_TWO);
    valid_d = (state_d != ST_EMPTY);
    case (state_d)
      ST_ONE:  count_d = 2'd1;
      ST_TWO:  count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  // Stall accounting ignores flush: it observes the downstream interface only.
  always_comb begin
    stall_d = stall_q;
    if (valid_q && !ready_i && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      count_q <= 2'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign data_o      = main_q;
  assign count_o     = count_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: vector table plus hand-built multi-cycle sequences.
// A second instance with a 2-bit stall counter exercises saturation.
module tb_pipe_skid_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        flush_i, valid_i, ready_i;
  logic [31:0] data_i;
  logic        ready_o, valid_o;
  logic [31:0] data_o;
  logic [1:0]  count_o;
  logic [15:0] stall_cnt_o;

  logic       s_flush, s_valid, s_ready;
  logic [7:0] s_data;
  logic       s_ready_o, s_valid_o;
  logic [7:0] s_data_o;
  logic [1:0] s_count_o;
  logic [1:0] s_stall_o;

  pipe_skid_stage #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .count_o(count_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_skid_stage #(.DATA_W(8), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .flush_i(s_flush),
    .valid_i(s_valid), .ready_o(s_ready_o), .data_i(s_data),
    .valid_o(s_valid_o), .ready_i(s_ready), .data_o(s_data_o),
    .count_o(s_count_o), .stall_cnt_o(s_stall_o)
  );

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        exp_vo;
    logic        exp_ro;
    logic [31:0] exp_do;
    logic [1:0]  exp_cnt;
    logic        chk_d;
  } vec_t;

  vec_t vecs[15];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic f, input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    flush_i = f;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] dmask;

    // flush, valid, data, ready | valid_o, ready_o, data_o, count_o, check data
    vecs[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0A, 1'b0, 1'b1, 1'b1, 32'h0A, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0B, 1'b0, 1'b1, 1'b0, 32'h0A, 2'd2, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 1'b1, 32'h0B, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55, 2'd1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 32'h00, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h01, 1'b0, 1'b1, 1'b1, 32'h01, 2'd1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h02, 1'b0, 1'b1, 1'b0, 32'h01, 2'd2, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0, 1'b0};

    rst_i   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    s_flush = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_ready = 1'b1;

    // Reset state, before any clock edge.
    #3;
    check("reset_main", {valid_o, ready_o, data_o, count_o, stall_cnt_o}, 64'h0);
    check("reset_sat", {s_valid_o, s_ready_o, s_data_o, s_count_o, s_stall_o}, 64'h0);

    // Release mid-cycle; ready_o comes up on the next rising edge.
    #9;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {valid_o, ready_o, count_o}, {1'b0, 1'b1, 2'd0});

    // Vector table: streaming, backpressure into SKID, flush in ONE and in TWO.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].flush, vecs[i].valid, vecs[i].data, vecs[i].ready);
      dmask = vecs[i].chk_d ? 32'hFFFF_FFFF : 32'h0;
      check($sformatf("vec%0d", i),
            {valid_o, ready_o, count_o, data_o & dmask},
            {vecs[i].exp_vo, vecs[i].exp_ro, vecs[i].exp_cnt, vecs[i].exp_do & dmask});
    end
    // Stalled edges in the table: rows 5, 9 (coincides with flush) and 12.
    check("stall_after_table", {48'h0, stall_cnt_o}, 64'd3);

    // Asynchronous reset while holding two payloads.
    step(1'b0, 1'b1, 32'hC1, 1'b0);
    step(1'b0, 1'b1, 32'hC2, 1'b0);
    check("two_before_reset", {valid_o, ready_o, count_o, data_o}, {1'b1, 1'b0, 2'd2, 32'hC1});
    #2;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    #1;
    check("async_reset_outputs", {valid_o, ready_o, data_o, count_o, stall_cnt_o}, 64'h0);
    #3;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midreset", {valid_o, ready_o, count_o}, {1'b0, 1'b1, 2'd0});
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("nothing_after_reset", {valid_o, count_o}, {1'b0, 2'd0});

    // Sustained stall in TWO: entering TWO is itself one stalled edge.
    step(1'b0, 1'b1, 32'hA, 1'b1);
    check("stall_base", {48'h0, stall_cnt_o}, 64'd0);
    step(1'b0, 1'b1, 32'hB, 1'b0);
    check("enter_two", {count_o, ready_o, stall_cnt_o}, {2'd2, 1'b0, 16'd1});
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check($sformatf("stall_hold%0d", k),
            {valid_o, data_o, stall_cnt_o}, {1'b1, 32'hA, 16'(1 + k)});
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("drain_b", {valid_o, data_o, count_o}, {1'b1, 32'hB, 2'd1});
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("drain_empty", {valid_o, count_o, stall_cnt_o}, {1'b0, 2'd0, 16'd6});

    // Saturation with a 2-bit stall counter.
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    s_ready = 1'b0;
    @(posedge clk);
    #1;
    check("sat_load", {s_valid_o, s_data_o, s_stall_o}, {1'b1, 8'h5A, 2'd0});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("sat_stall%0d", k),
            {s_valid_o, s_data_o, s_stall_o}, {1'b1, 8'h5A, (k < 3) ? 2'(k) : 2'd3});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
